// File: rtl/k12a_fetch_unit_pkg.sv
// Shared types and constants for the k12a instruction fetch unit.
// Holds the fetch FSM state encoding and the default reset PC.
package k12a_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_STATE_IDLE = 2'd0,
      FETCH_STATE_HI   = 2'd1,
      FETCH_STATE_LO   = 2'd2,
      FETCH_STATE_DONE = 2'd3
   } fetch_state_t;

   localparam logic [15:0] K12A_RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/k12a_fetch_unit_program_counter.sv
// 16-bit program counter with restore > load > increment priority.
// Arithmetic wraps modulo 2^16.
module k12a_program_counter #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        inc,
   input  logic        restore,
   input  logic [15:0] restore_value,
   output logic [15:0] pc
);

   logic [15:0] pc_d;
   logic [15:0] pc_q;

   // NOTE: pc_d gets a default before any branch so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      pc_d = pc_q;
      if (restore) begin
         pc_d = restore_value;
      end else if (load) begin
         pc_d = load_value;
      end else if (inc) begin
         pc_d = pc_q + 16'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/k12a_fetch_unit.sv
// Instruction fetch: assembles a big-endian 16-bit instruction from two byte reads.
// Optional per-byte wait timeout is enabled by defining K12A_FETCH_TIMEOUT_EN.
module k12a_fetch_unit
   import k12a_fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = K12A_RESET_PC_DEFAULT
`ifdef K12A_FETCH_TIMEOUT_EN
  ,parameter int          TIMEOUT_CYCLES = 16
`endif
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_start,
   input  logic        pc_load,
   input  logic [15:0] pc_load_value,
   input  logic [7:0]  data_bus,
   input  logic        mem_ready,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   output logic [15:0] inst,
   output logic [15:0] pc,
   output logic        busy,
   output logic        fetch_done
`ifdef K12A_FETCH_TIMEOUT_EN
  ,output logic        fetch_error
`endif
);

   fetch_state_t state_d, state_q;
   logic [7:0]   hi_d, hi_q;
   logic [15:0]  inst_d, inst_q;
   logic         pc_load_en;
   logic         pc_inc;
   logic         pc_restore;
   logic [15:0]  pc_restore_value;

`ifdef K12A_FETCH_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_d, wait_q;
   logic [15:0]       start_pc_d, start_pc_q;
   logic              fetch_error_d, fetch_error_q;
`endif

   always_comb begin
      state_d          = state_q;
      hi_d             = hi_q;
      inst_d           = inst_q;
      pc_load_en       = 1'b0;
      pc_inc           = 1'b0;
      pc_restore       = 1'b0;
      pc_restore_value = 16'h0000;
`ifdef K12A_FETCH_TIMEOUT_EN
      wait_d           = '0;
      start_pc_d       = start_pc_q;
      fetch_error_d    = 1'b0;
`endif
      unique case (state_q)
         FETCH_STATE_IDLE: begin
            pc_load_en = pc_load;
            if (fetch_start) begin
               state_d = FETCH_STATE_HI;
`ifdef K12A_FETCH_TIMEOUT_EN
               start_pc_d = pc_load ? pc_load_value : pc;
`endif
            end
         end
         FETCH_STATE_HI, FETCH_STATE_LO: begin
            if (mem_ready) begin
               pc_inc = 1'b1;
               if (state_q == FETCH_STATE_HI) begin
                  hi_d    = data_bus;
                  state_d = FETCH_STATE_LO;
               end else begin
                  inst_d  = {hi_q, data_bus};
                  state_d = FETCH_STATE_DONE;
               end
`ifdef K12A_FETCH_TIMEOUT_EN
            end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               // This is the last allowed wait cycle: abandon and rewind to the fetch origin.
               state_d          = FETCH_STATE_IDLE;
               pc_restore       = 1'b1;
               pc_restore_value = start_pc_q;
               fetch_error_d    = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
`endif
            end
         end
         FETCH_STATE_DONE: begin
            state_d = FETCH_STATE_IDLE;
         end
         default: begin
            state_d = FETCH_STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FETCH_STATE_IDLE;
         hi_q    <= 8'h00;
         inst_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         inst_q  <= inst_d;
      end
   end

`ifdef K12A_FETCH_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_q        <= '0;
         start_pc_q    <= RESET_PC;
         fetch_error_q <= 1'b0;
      end else begin
         wait_q        <= wait_d;
         start_pc_q    <= start_pc_d;
         fetch_error_q <= fetch_error_d;
      end
   end

   assign fetch_error = fetch_error_q;
`endif

   k12a_program_counter #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clock         (clock),
      .reset         (reset),
      .load          (pc_load_en),
      .load_value    (pc_load_value),
      .inc           (pc_inc),
      .restore       (pc_restore),
      .restore_value (pc_restore_value),
      .pc            (pc)
   );

   assign mem_rd     = (state_q == FETCH_STATE_HI) || (state_q == FETCH_STATE_LO);
   assign busy       = (state_q != FETCH_STATE_IDLE);
   assign fetch_done = (state_q == FETCH_STATE_DONE);
   assign mem_addr   = pc;
   assign inst       = inst_q;

endmodule

// File: tb/tb_k12a_fetch_unit.sv
// Self-checking bench for k12a_fetch_unit: vector table, hand-written corner
// sequences and a scoreboard of expected {inst, pc} per fetch.
module tb_k12a_fetch_unit;

   logic        clock;
   logic        reset;
   logic        fetch_start;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic [7:0]  data_bus;
   logic        mem_ready;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] inst;
   logic [15:0] pc;
   logic        busy;
   logic        fetch_done;
`ifdef K12A_FETCH_TIMEOUT_EN
   logic        fetch_error;
`endif

   logic [7:0] mem [65536];
   assign data_bus = mem[mem_addr];

   k12a_fetch_unit #(
      .RESET_PC       (16'h0000)
`ifdef K12A_FETCH_TIMEOUT_EN
     ,.TIMEOUT_CYCLES (4)
`endif
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .fetch_start   (fetch_start),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .data_bus      (data_bus),
      .mem_ready     (mem_ready),
      .mem_rd        (mem_rd),
      .mem_addr      (mem_addr),
      .inst          (inst),
      .pc            (pc),
      .busy          (busy),
      .fetch_done    (fetch_done)
`ifdef K12A_FETCH_TIMEOUT_EN
     ,.fetch_error   (fetch_error)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] inst;
      logic [15:0] pc;
   } sb_entry_t;

   typedef struct {
      logic [15:0] start_pc;
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic [15:0] exp_inst;
      logic [15:0] exp_pc;
   } vec_t;

   sb_entry_t sb[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] p);
      sb_entry_t e;
      e.inst = i;
      e.pc   = p;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string name);
      sb_entry_t e;
      if (sb.size() == 0) begin
         check({name, "_sb_nonempty"}, 32'(sb.size()), 1);
      end else begin
         e = sb.pop_front();
         check({name, "_inst"}, inst, e.inst);
         check({name, "_pc"}, pc, e.pc);
      end
   endtask

   // Single-cycle fetch_start; returns positioned in cycle 1.
   task automatic start_fetch();
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
   endtask

   task automatic load_pc(input logic [15:0] v);
      pc_load       = 1'b1;
      pc_load_value = v;
      tick();
      pc_load       = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int cycles);
      cycles = 0;
      while (fetch_done !== 1'b1 && cycles < budget) begin
         tick();
         cycles++;
      end
      check({name, "_done_seen"}, fetch_done, 1);
      if (fetch_done === 1'b1) pop_check(name);
   endtask

   task automatic apply_reset();
      reset         = 1'b1;
      fetch_start   = 1'b0;
      pc_load       = 1'b0;
      pc_load_value = 16'h0000;
      mem_ready     = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      int   cyc;
      logic [15:0] a1;

      vecs[0] = '{start_pc: 16'h0100, hi: 8'h12, lo: 8'h34, exp_inst: 16'h1234, exp_pc: 16'h0102};
      vecs[1] = '{start_pc: 16'hABCD, hi: 8'hFF, lo: 8'h00, exp_inst: 16'hFF00, exp_pc: 16'hABCF};
      vecs[2] = '{start_pc: 16'hFFFE, hi: 8'h5A, lo: 8'hC3, exp_inst: 16'h5AC3, exp_pc: 16'h0000};
      vecs[3] = '{start_pc: 16'h7FFF, hi: 8'h00, lo: 8'hFF, exp_inst: 16'h00FF, exp_pc: 16'h8001};

      reset = 1'b1;
      apply_reset();

      check("rst_pc", pc, 16'h0000);
      check("rst_inst", inst, 16'h0000);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_busy", busy, 0);
      check("rst_fetch_done", fetch_done, 0);

      // mem_ready while idle must not move the PC.
      mem_ready = 1'b1;
      repeat (3) tick();
      check("idle_ready_pc", pc, 16'h0000);
      check("idle_ready_busy", busy, 0);

      // Basic fetch with per-cycle visibility.
      mem[16'h0000] = 8'h14;
      mem[16'h0001] = 8'hA5;
      check("basic_c0_mem_rd", mem_rd, 0);
      push(16'h14A5, 16'h0002);
      start_fetch();
      check("basic_c1_mem_rd", mem_rd, 1);
      check("basic_c1_addr", mem_addr, 16'h0000);
      tick();
      check("basic_c2_mem_rd", mem_rd, 1);
      check("basic_c2_addr", mem_addr, 16'h0001);
      check("basic_c2_inst_held", inst, 16'h0000);
      tick();
      check("basic_c3_done", fetch_done, 1);
      check("basic_c3_mem_rd", mem_rd, 0);
      pop_check("basic");
      tick();
      check("basic_c4_done_clear", fetch_done, 0);
      check("basic_c4_busy", busy, 0);

      // Five wait cycles in FETCH_HI.
      apply_reset();
      mem_ready = 1'b0;
      push(16'h14A5, 16'h0002);
      start_fetch();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall_addr_%0d", i), mem_addr, 16'h0000);
         check($sformatf("stall_busy_%0d", i), busy, 1);
         check($sformatf("stall_inst_%0d", i), inst, 16'h0000);
         tick();
      end
      mem_ready = 1'b1;
      wait_done("stall", 10, cyc);
      check("stall_latency", 32'(6 + cyc), 8);

      // Load and start together, straddling the PC wrap.
      mem[16'hFFFF] = 8'h7C;
      mem[16'h0000] = 8'h01;
      tick();
      pc_load       = 1'b1;
      pc_load_value = 16'hFFFF;
      fetch_start   = 1'b1;
      push(16'h7C01, 16'h0001);
      tick();
      pc_load     = 1'b0;
      fetch_start = 1'b0;
      check("wrap_c1_addr", mem_addr, 16'hFFFF);
      wait_done("wrap", 10, cyc);
      check("wrap_latency", 32'(cyc + 1), 3);
      tick();

      // Vector table.
      for (int v = 0; v < 4; v++) begin
         a1 = vecs[v].start_pc + 16'd1;
         mem[vecs[v].start_pc] = vecs[v].hi;
         mem[a1]               = vecs[v].lo;
         load_pc(vecs[v].start_pc);
         check($sformatf("tbl%0d_loaded_pc", v), pc, vecs[v].start_pc);
         push(vecs[v].exp_inst, vecs[v].exp_pc);
         start_fetch();
         wait_done($sformatf("tbl%0d", v), 10, cyc);
         check($sformatf("tbl%0d_latency", v), 32'(cyc + 1), 3);
         tick();
      end

      // fetch_start/pc_load during FETCH_LO and DONE are dropped.
      mem[16'h0200] = 8'h9A;
      mem[16'h0201] = 8'hBC;
      load_pc(16'h0200);
      push(16'h9ABC, 16'h0202);
      start_fetch();
      tick();
      check("ign_c2_addr", mem_addr, 16'h0201);
      fetch_start   = 1'b1;
      pc_load       = 1'b1;
      pc_load_value = 16'h1234;
      tick();
      check("ign_c3_done", fetch_done, 1);
      pop_check("ign");
      tick();
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      check("ign_c4_busy", busy, 0);
      check("ign_c4_pc", pc, 16'h0202);
      repeat (2) begin
         tick();
         check("ign_no_extra_done", fetch_done, 0);
      end

      // Reset asserted in FETCH_LO after the hi byte was taken.
      mem[16'h0040] = 8'hEE;
      mem[16'h0041] = 8'h55;
      load_pc(16'h0040);
      start_fetch();
      tick();
      check("rstlo_in_lo", mem_addr, 16'h0041);
      #2;
      reset = 1'b1;
      #1;
      check("rstlo_pc", pc, 16'h0000);
      check("rstlo_inst", inst, 16'h0000);
      check("rstlo_mem_rd", mem_rd, 0);
      check("rstlo_done", fetch_done, 0);
      tick();
      reset = 1'b0;
      repeat (3) begin
         tick();
         check("rstlo_no_done", fetch_done, 0);
      end
      check("rstlo_inst_after", inst, 16'h0000);

`ifdef K12A_FETCH_TIMEOUT_EN
      check("to_err_idle", fetch_error, 0);
      load_pc(16'h0010);
      mem_ready = 1'b0;
      start_fetch();
      repeat (3) tick();
      check("to_c4_busy", busy, 1);
      check("to_c4_err", fetch_error, 0);
      tick();
      check("to_c5_err", fetch_error, 1);
      check("to_c5_busy", busy, 0);
      check("to_c5_pc", pc, 16'h0010);
      check("to_c5_done", fetch_done, 0);
      check("to_c5_inst", inst, 16'h0000);
      tick();
      check("to_c6_err_clear", fetch_error, 0);
      check("to_c6_done", fetch_done, 0);
`endif

      check("sb_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/k12a_fetch_unit.md
Name: k12a_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the ALU.
- Reads a 16-bit instruction as two big-endian bytes over the 8-bit data bus, holding a memory read request until the memory handshakes each byte.
- Presents the assembled instruction atomically on `inst`, which the ALU and decoder consume combinationally.
- Owns the program counter: increments after each byte fetched, and accepts absolute loads for jumps.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT_CYCLES, 16, maximum wait cycles per byte (used only with the optional feature).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_start  input  1  single-cycle request to fetch the next instruction.
- pc_load  input  1  load PC from pc_load_value.
- pc_load_value  input  16  jump target.
- data_bus  input  8  memory read data, valid when mem_ready=1.
- mem_ready  input  1  memory has data for the current mem_addr.
- mem_rd  output  1  memory read request.
- mem_addr  output  16  read address; always equals pc.
- inst  output  16  last completed instruction.
- pc  output  16  program counter.
- busy  output  1  high whenever state != IDLE.
- fetch_done  output  1  one-cycle pulse; inst is updated in the same cycle.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, inst=16'h0000, internal hi-byte latch=8'h00.
  - mem_rd=0, fetch_done=0.
  - Reset mid-fetch abandons the fetch with no partial update visible.
- States are IDLE, FETCH_HI, FETCH_LO, DONE.
- IDLE:
  - mem_rd=0.
  - If pc_load=1, then pc<=pc_load_value.
  - If fetch_start=1, go to FETCH_HI.
  - Both together: the load applies and the fetch starts from the loaded address.
- FETCH_HI:
  - mem_rd=1.
  - On an edge with mem_ready=1: hi latch<=data_bus, pc<=pc+1, go to FETCH_LO.
  - Otherwise stay, holding the address.
- FETCH_LO:
  - mem_rd=1.
  - On an edge with mem_ready=1: inst<={hi latch, data_bus}, pc<=pc+1, go to DONE.
- DONE:
  - fetch_done=1 for exactly one cycle, then go to IDLE.
  - fetch_start is not accepted in DONE.
- Latency:
  - With mem_ready tied high, fetch_start in cycle 0 gives FETCH_HI in cycle 1, FETCH_LO in cycle 2, and fetch_done in cycle 3.
  - Minimum spacing between accepted fetch_start pulses is 4 cycles.
- Boundary rules:
  - fetch_start or pc_load while busy is ignored (not queued).
  - mem_ready while mem_rd=0 is ignored.
  - PC arithmetic is modulo 2^16: 16'hFFFF+1 -> 16'h0000. An instruction may straddle the wrap, with the hi byte at FFFF and the lo byte at 0000.
  - inst never shows a half-assembled value; it changes only on the FETCH_LO handshake.

Optional Feature:
- Macro: K12A_FETCH_TIMEOUT_EN.
- Defined:
  - Adds output fetch_error (1 bit, reset 0) and a wait counter, width $clog2(TIMEOUT_CYCLES+1).
  - The counter clears on entry to FETCH_HI/FETCH_LO and on each handshake, and increments on every waiting cycle.
  - When it reaches TIMEOUT_CYCLES with no handshake: go to IDLE, restore pc to the address the fetch started at, leave inst unchanged, pulse fetch_error for one cycle, and do not pulse fetch_done.
- Undefined: no port, no counter; the unit waits indefinitely.

Decomposition:
- k12a.inc.sv gains the typedef enum fetch_state_t (FETCH_STATE_IDLE, FETCH_STATE_HI, FETCH_STATE_LO, FETCH_STATE_DONE) and the localparam K12A_RESET_PC_DEFAULT.
- One natural sub-module, k12a_program_counter:
  - Inputs: clock, reset, load, load_value, inc, restore, restore_value.
  - Output: 16-bit pc.
  - Priority: restore > load > inc.
- FSM and instruction assembly stay in the top module.

Test Plan:
- Reset then fetch_start, mem_ready=1, memory[0000]=8'h14, [0001]=8'hA5 -> fetch_done in cycle 3, inst=16'h14A5, pc=16'h0002, mem_rd high only in cycles 1-2.
- mem_ready held low 5 cycles in FETCH_HI (feature off) -> mem_addr stable at 16'h0000, busy=1, inst unchanged until completion, total fetch_done at cycle 8.
- pc_load=1 with pc_load_value=16'hFFFF and fetch_start same cycle, memory[FFFF]=8'h7C, [0000]=8'h01 -> inst=16'h7C01, pc=16'h0001.
- fetch_start and pc_load pulsed during FETCH_LO -> both ignored, pc increments normally, only one fetch_done.
- Assert reset in FETCH_LO after hi byte 8'hEE taken -> pc=RESET_PC, inst=16'h0000, mem_rd=0 immediately, no fetch_done.
- K12A_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, pc=16'h0010, mem_ready low forever -> fetch_error pulse after 4 wait cycles, pc=16'h0010, state IDLE, no fetch_done.
